// File: rtl/pipemdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states, iteration count.
package pipemdu_ctrl_pkg;

    typedef logic [1:0] mdu_op_t;

    localparam mdu_op_t MDU_MULT  = 2'b00;
    localparam mdu_op_t MDU_MULTU = 2'b01;
    localparam mdu_op_t MDU_DIV   = 2'b10;
    localparam mdu_op_t MDU_DIVU  = 2'b11;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int MDU_STEPS = 32;

endpackage

// File: rtl/pipemdu_ctrl_if.sv
// E-stage side of the multiply/divide unit: issue/decode inputs, stall and HI/LO results out.
interface pipemdu_ctrl_if;
    import pipemdu_ctrl_pkg::*;

    logic        estart;
    mdu_op_t     eop;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        emfhi;
    logic        emflo;
    logic        estall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] ehilo;
    logic        done;

    modport master (
        output estart, eop, ea, eb, emfhi, emflo,
        input  estall, busy, hi, lo, ehilo, done
    );

    modport slave (
        input  estart, eop, ea, eb, emfhi, emflo,
        output estall, busy, hi, lo, ehilo, done
    );

endinterface

// File: rtl/pipemdu_ctrl_mdu_step.sv
// One combinational iteration: shift-add multiply on {acc, multiplier} or restoring divide on {rem, quot}.
module mdu_step (
    input  logic        i_div,
    input  logic [63:0] i_work,
    input  logic [31:0] i_opd,
    output logic [63:0] o_work
);

    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic [32:0] w_diff;
    logic        w_ge;
    logic [31:0] w_rem_new;

    assign w_sum     = {1'b0, i_work[63:32]} + (i_work[0] ? {1'b0, i_opd} : 33'd0);
    assign w_rem_sh  = {i_work[63:32], i_work[31]};
    assign w_diff    = w_rem_sh - {1'b0, i_opd};
    assign w_ge      = ~w_diff[32];
    // When the trial subtract fails the shifted remainder is below the divisor, so 32 bits hold it.
    assign w_rem_new = w_ge ? w_diff[31:0] : w_rem_sh[31:0];

    always_comb begin
        o_work = {w_sum, i_work[31:1]};
        if (i_div) begin
            o_work = {w_rem_new, i_work[30:0], w_ge};
        end
    end

endmodule

// File: rtl/pipemdu_ctrl.sv
// HI/LO owner and 32-step mult/div sequencer; stalls the front of the pipe on HI/LO consumers while busy.
module pipemdu_ctrl
    import pipemdu_ctrl_pkg::*;
#(
    parameter int STEPS = MDU_STEPS
) (
    input  logic           clk,
    input  logic           clrn,
    pipemdu_ctrl_if.slave  mdu
);

    localparam int CW = $clog2(STEPS);

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_work;
    logic [31:0]   r_opd;
    logic          r_div;
    logic          r_neg_q;
    logic          r_neg_r;
    logic [31:0]   r_hi;
    logic [31:0]   r_lo;

    logic          w_signed;
    logic          w_div;
    logic          w_sa;
    logic          w_sb;
    logic [31:0]   w_abs_a;
    logic [31:0]   w_abs_b;
    logic          w_accept;
    logic [63:0]   w_next;
    logic [63:0]   w_prod;
    logic [31:0]   w_quot;
    logic [31:0]   w_rem;

    assign w_signed = ~mdu.eop[0];
    assign w_div    = mdu.eop[1];
    assign w_sa     = w_signed & mdu.ea[31];
    assign w_sb     = w_signed & mdu.eb[31];
    assign w_abs_a  = w_sa ? -mdu.ea : mdu.ea;
    assign w_abs_b  = w_sb ? -mdu.eb : mdu.eb;
    assign w_accept = (r_state == S_IDLE) & mdu.estart;

    mdu_step u_step (
        .i_div  (r_div),
        .i_work (r_work),
        .i_opd  (r_opd),
        .o_work (w_next)
    );

    // Remainder is restored to the dividend's sign; with a zero divisor that reproduces ea exactly.
    assign w_prod = r_neg_q ? -r_work : r_work;
    assign w_quot = r_neg_q ? -r_work[31:0] : r_work[31:0];
    assign w_rem  = r_neg_r ? -r_work[63:32] : r_work[63:32];

    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_work  <= '0;
            r_opd   <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_CALC;
                        r_cnt   <= '0;
                        r_div   <= w_div;
                        r_opd   <= w_div ? w_abs_b : w_abs_a;
                        r_work  <= {32'd0, (w_div ? w_abs_a : w_abs_b)};
                        // Divide by zero keeps the all-ones quotient uncorrected.
                        r_neg_q <= (w_sa ^ w_sb) & (~w_div | (|mdu.eb));
                        r_neg_r <= w_div & w_sa;
                    end
                end
                S_CALC: begin
                    r_work <= w_next;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CW'(STEPS - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_hi    <= r_div ? w_rem  : w_prod[63:32];
                    r_lo    <= r_div ? w_quot : w_prod[31:0];
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mdu.busy   = (r_state != S_IDLE);
    assign mdu.done   = (r_state == S_FIX);
    assign mdu.estall = mdu.busy & (mdu.estart | mdu.emfhi | mdu.emflo);
    assign mdu.hi     = r_hi;
    assign mdu.lo     = r_lo;
    assign mdu.ehilo  = mdu.emfhi ? r_hi : r_lo;

endmodule

// File: tb/tb_pipemdu_ctrl.sv
// Directed bench for pipemdu_ctrl: hand-computed HI/LO results, latency, stall and reset behaviour.
module tb_pipemdu_ctrl;
    import pipemdu_ctrl_pkg::*;

    logic clk;
    logic clrn;
    int   n_checks;
    int   n_errors;

    pipemdu_ctrl_if bus ();

    pipemdu_ctrl dut (
        .clk  (clk),
        .clrn (clrn),
        .mdu  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op in the current (idle) cycle and follow it to completion.
    task automatic run_op(input string tag, input mdu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        @(negedge clk);
        bus.estart = 1'b1;
        bus.eop    = op;
        bus.ea     = a;
        bus.eb     = b;
        #1;
        check({tag, " issue_stall"}, 64'(bus.estall), 64'd0);
        @(negedge clk);
        bus.estart = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            busy_cnt++;
            if (bus.done) done_cnt++;
            @(negedge clk);
        end
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
        bus.emfhi = 1'b1;
        #1;
        check({tag, " ehilo_hi"}, 64'(bus.ehilo), 64'(exp_hi));
        bus.emfhi = 1'b0;
        #1;
        check({tag, " ehilo_lo"}, 64'(bus.ehilo), 64'(exp_lo));
    endtask

    initial begin
        int cnt;
        n_checks   = 0;
        n_errors   = 0;
        clrn       = 1'b1;
        bus.estart = 1'b1;
        bus.eop    = MDU_MULT;
        bus.ea     = 32'd0;
        bus.eb     = 32'd0;
        bus.emfhi  = 1'b1;
        bus.emflo  = 1'b0;
        #12;
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst estall", 64'(bus.estall), 64'd0);
        check("rst hi", 64'(bus.hi), 64'd0);
        check("rst lo", 64'(bus.lo), 64'd0);
        bus.estart = 1'b0;
        bus.emfhi  = 1'b0;
        @(negedge clk);
        clrn = 1'b0;

        run_op("mult7x-3",    MDU_MULT,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu_max",   MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_minsq",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div-7/2",     MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu9/0",     MDU_DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFF_FFFF);
        run_op("div-5/0",     MDU_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_min/-1",  MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        run_op("divu100/7",   MDU_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);

        // mult 5 x 6 with mflo held in E from T0+2 until the stall releases
        @(negedge clk);
        bus.estart = 1'b1;
        bus.eop    = MDU_MULT;
        bus.ea     = 32'd5;
        bus.eb     = 32'd6;
        @(negedge clk);
        bus.estart = 1'b0;
        #1;
        check("mflo no_consumer_stall", 64'(bus.estall), 64'd0);
        @(negedge clk);
        bus.emflo = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.estall) break;
            cnt++;
            @(negedge clk);
        end
        check("mflo stall_cycles", 64'(cnt), 64'd32);
        check("mflo ehilo", 64'(bus.ehilo), 64'd30);
        bus.emflo = 1'b0;

        run_op("mult7x-3b", MDU_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // back-to-back: mfhi alongside the accepting estart reads the old HI
        @(negedge clk);
        bus.estart = 1'b1;
        bus.eop    = MDU_MULT;
        bus.ea     = 32'd2;
        bus.eb     = 32'd3;
        bus.emfhi  = 1'b1;
        #1;
        check("b2b accept_stall", 64'(bus.estall), 64'd0);
        check("b2b old_hi", 64'(bus.ehilo), 64'hFFFF_FFFF);
        @(negedge clk);
        bus.emfhi = 1'b0;
        bus.ea    = 32'hFFFF_FFFC;
        bus.eb    = 32'd5;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!bus.estall) break;
            cnt++;
            @(negedge clk);
        end
        check("b2b stall_cycles", 64'(cnt), 64'd33);
        check("b2b first_lo", 64'(bus.lo), 64'd6);
        check("b2b first_hi", 64'(bus.hi), 64'd0);
        @(negedge clk);
        bus.estart = 1'b0;
        check("b2b second_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) break;
            @(negedge clk);
        end
        check("b2b second_busy_end", 64'(bus.busy), 64'd0);
        check("b2b second_hi", 64'(bus.hi), 64'hFFFF_FFFF);
        check("b2b second_lo", 64'(bus.lo), 64'hFFFF_FFEC);

        // reset in the middle of CALC
        @(negedge clk);
        bus.estart = 1'b1;
        bus.eop    = MDU_MULTU;
        bus.ea     = 32'h0001_2345;
        bus.eb     = 32'h0000_0777;
        @(negedge clk);
        bus.estart = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst busy_before", 64'(bus.busy), 64'd1);
        clrn      = 1'b1;
        bus.emfhi = 1'b1;
        #1;
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst estall", 64'(bus.estall), 64'd0);
        check("midrst done", 64'(bus.done), 64'd0);
        check("midrst hi", 64'(bus.hi), 64'd0);
        check("midrst lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        clrn      = 1'b0;
        bus.emfhi = 1'b0;

        run_op("post_rst 2x3", MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
